// File: rtl/gt_link_pkg.sv
// Shared definitions for the GT link bring-up sequencer.
// Contents:
//   state_e          - 4-bit state encoding, ST_IDLE (0) .. ST_FAIL (8)
//   GT_DEF_*         - default parameter values, shared with the bench
//   gt_sat_inc4      - 4-bit saturating increment
package gt_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_PLL = 4'd1,
    ST_TX_RST   = 4'd2,
    ST_TX_WAIT  = 4'd3,
    ST_RX_RST   = 4'd4,
    ST_RX_WAIT  = 4'd5,
    ST_ALIGN    = 4'd6,
    ST_LINK_UP  = 4'd7,
    ST_FAIL     = 4'd8
  } state_e;

  localparam int unsigned GT_DEF_RST_HOLD_CYC     = 32;
  localparam int unsigned GT_DEF_TIMEOUT_CYC      = 1048576;
  localparam int unsigned GT_DEF_TIMER_W          = 21;
  localparam int unsigned GT_DEF_ALIGN_STABLE_CYC = 1024;
  localparam int unsigned GT_DEF_LOSS_CYC         = 8;
  localparam int unsigned GT_DEF_MAX_RETRY        = 7;
  localparam bit          GT_DEF_POL_FLIP_EN      = 1'b1;

  function automatic logic [3:0] gt_sat_inc4(input logic [3:0] i_v);
    return (i_v == 4'hF) ? i_v : i_v + 4'd1;
  endfunction

endpackage

// File: rtl/gt_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   i_clk - destination clock
//   i_rst - asynchronous active-high reset, flops load RST_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output, two i_clk cycles behind i_d
module gt_sync_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gt_link_ctrl.sv
// Link bring-up and recovery sequencer for one GT channel (i_sysclk domain).
// Ports:
//   i_sysclk, i_rst      - free-running clock, async active-high reset
//   i_enable             - level: high brings up and holds the link
//   i_qplllock, i_tx_done, i_rx_done, i_rx_byte_align - async status, synchronized here
//   o_tx_rst, o_rx_rst   - channel soft resets
//   o_rx_polarity        - RX polarity select, flipped on ALIGN timeouts
//   o_link_up, o_fail    - link usable / retries exhausted
//   o_state, o_retry_cnt - debug state encoding and timeouts since last link-up
module gt_link_ctrl
  import gt_link_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC     = GT_DEF_RST_HOLD_CYC,
  parameter int unsigned TIMEOUT_CYC      = GT_DEF_TIMEOUT_CYC,
  parameter int unsigned TIMER_W          = GT_DEF_TIMER_W,
  parameter int unsigned ALIGN_STABLE_CYC = GT_DEF_ALIGN_STABLE_CYC,
  parameter int unsigned LOSS_CYC         = GT_DEF_LOSS_CYC,
  parameter int unsigned MAX_RETRY        = GT_DEF_MAX_RETRY,
  parameter bit          POL_FLIP_EN      = GT_DEF_POL_FLIP_EN
) (
  input  logic       i_sysclk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_qplllock,
  input  logic       i_tx_done,
  input  logic       i_rx_done,
  input  logic       i_rx_byte_align,
  output logic       o_tx_rst,
  output logic       o_rx_rst,
  output logic       o_rx_polarity,
  output logic       o_link_up,
  output logic       o_fail,
  output logic [3:0] o_state,
  output logic [3:0] o_retry_cnt
);

  logic w_pll_s;
  logic w_txd_s;
  logic w_rxd_s;
  logic w_aln_s;

  gt_sync_bit #(.RST_VAL(1'b0)) u_sync_pll (
    .i_clk(i_sysclk), .i_rst(i_rst), .i_d(i_qplllock), .o_q(w_pll_s)
  );
  gt_sync_bit #(.RST_VAL(1'b0)) u_sync_txd (
    .i_clk(i_sysclk), .i_rst(i_rst), .i_d(i_tx_done), .o_q(w_txd_s)
  );
  gt_sync_bit #(.RST_VAL(1'b0)) u_sync_rxd (
    .i_clk(i_sysclk), .i_rst(i_rst), .i_d(i_rx_done), .o_q(w_rxd_s)
  );
  gt_sync_bit #(.RST_VAL(1'b0)) u_sync_aln (
    .i_clk(i_sysclk), .i_rst(i_rst), .i_d(i_rx_byte_align), .o_q(w_aln_s)
  );

  state_e             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] r_stable;
  logic [TIMER_W-1:0] r_loss;
  logic [3:0]         r_retry_cnt;
  logic               r_tx_rst;
  logic               r_rx_rst;
  logic               r_rx_pol;
  logic               r_link_up;
  logic               r_fail;

  state_e     w_nxt;
  logic       w_wait_st;
  logic       w_timeout;
  logic       w_pll_lost;
  logic       w_hold_done;
  logic       w_loss;
  logic       w_retry;
  logic       w_pol_flip;
  logic [3:0] w_retry_inc;

  assign w_wait_st = (r_state == ST_WAIT_PLL) || (r_state == ST_TX_WAIT) ||
                     (r_state == ST_RX_WAIT)  || (r_state == ST_ALIGN);
  assign w_timeout   = w_wait_st && (r_timer == TIMER_W'(TIMEOUT_CYC - 1));
  assign w_hold_done = (r_timer == TIMER_W'(RST_HOLD_CYC - 1));
  assign w_pll_lost  = !w_pll_s && (r_state >= ST_TX_RST) && (r_state <= ST_LINK_UP);
  // Loss fires on the LOSS_CYC-th consecutive unaligned cycle itself.
  assign w_loss      = (r_state == ST_LINK_UP) && !w_aln_s &&
                       (r_loss == TIMER_W'(LOSS_CYC - 1));
  assign w_retry_inc = gt_sat_inc4(r_retry_cnt);

  always_comb begin
    w_nxt      = r_state;
    w_retry    = 1'b0;
    w_pol_flip = 1'b0;
    if (!i_enable) begin
      w_nxt = ST_IDLE;
    end else if (w_pll_lost) begin
      w_nxt = ST_WAIT_PLL;
    end else begin
      // Success checks come before the timeout so success wins a tie.
      unique case (r_state)
        ST_IDLE:     w_nxt = ST_WAIT_PLL;
        ST_WAIT_PLL: if (w_pll_s) w_nxt = ST_TX_RST; else w_retry = w_timeout;
        ST_TX_RST:   if (w_hold_done) w_nxt = ST_TX_WAIT;
        ST_TX_WAIT:  if (w_txd_s) w_nxt = ST_RX_RST; else w_retry = w_timeout;
        ST_RX_RST:   if (w_hold_done) w_nxt = ST_RX_WAIT;
        ST_RX_WAIT:  if (w_rxd_s) w_nxt = ST_ALIGN; else w_retry = w_timeout;
        ST_ALIGN: begin
          if (r_stable == TIMER_W'(ALIGN_STABLE_CYC)) w_nxt = ST_LINK_UP;
          else w_retry = w_timeout;
        end
        ST_LINK_UP:  if (w_loss) w_nxt = ST_RX_RST;
        ST_FAIL:     w_nxt = ST_FAIL;
        default:     w_nxt = ST_IDLE;
      endcase
      if (w_retry) begin
        if (w_retry_inc == 4'(MAX_RETRY)) begin
          w_nxt = ST_FAIL;
        end else if (r_state == ST_ALIGN) begin
          w_nxt      = ST_RX_RST;
          w_pol_flip = POL_FLIP_EN;
        end else begin
          w_nxt = ST_TX_RST;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as r_state.
  always_ff @(posedge i_sysclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_stable    <= '0;
      r_loss      <= '0;
      r_retry_cnt <= 4'd0;
      r_tx_rst    <= 1'b1;
      r_rx_rst    <= 1'b1;
      r_rx_pol    <= 1'b0;
      r_link_up   <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_nxt != r_state) r_timer <= '0;
      else if (!(&r_timer)) r_timer <= r_timer + TIMER_W'(1);

      if ((r_state == ST_ALIGN) && (w_nxt == ST_ALIGN) && w_aln_s) begin
        r_stable <= r_stable + TIMER_W'(1);
      end else begin
        r_stable <= '0;
      end

      if ((r_state == ST_LINK_UP) && (w_nxt == ST_LINK_UP) && !w_aln_s) begin
        r_loss <= r_loss + TIMER_W'(1);
      end else begin
        r_loss <= '0;
      end

      if (w_retry) r_retry_cnt <= w_retry_inc;
      else if ((w_nxt == ST_IDLE) || (w_nxt == ST_LINK_UP)) r_retry_cnt <= 4'd0;

      if (w_pol_flip) r_rx_pol <= ~r_rx_pol;

      r_link_up <= (w_nxt == ST_LINK_UP);
      r_fail    <= (w_nxt == ST_FAIL);
      unique case (w_nxt)
        ST_TX_WAIT, ST_RX_RST:             begin r_tx_rst <= 1'b0; r_rx_rst <= 1'b1; end
        ST_RX_WAIT, ST_ALIGN, ST_LINK_UP:  begin r_tx_rst <= 1'b0; r_rx_rst <= 1'b0; end
        default:                           begin r_tx_rst <= 1'b1; r_rx_rst <= 1'b1; end
      endcase
    end
  end

  assign o_state       = r_state;
  assign o_retry_cnt   = r_retry_cnt;
  assign o_tx_rst      = r_tx_rst;
  assign o_rx_rst      = r_rx_rst;
  assign o_rx_polarity = r_rx_pol;
  assign o_link_up     = r_link_up;
  assign o_fail        = r_fail;

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Directed bench for gt_link_ctrl with small timing parameters.
module tb_gt_link_ctrl;
  import gt_link_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pll;
  logic       txd;
  logic       rxd;
  logic       aln;
  logic       tx_rst;
  logic       rx_rst;
  logic       pol;
  logic       link_up;
  logic       fail;
  logic [3:0] state;
  logic [3:0] retry;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  gt_link_ctrl #(
    .RST_HOLD_CYC(4), .TIMEOUT_CYC(64), .TIMER_W(8), .ALIGN_STABLE_CYC(16),
    .LOSS_CYC(4), .MAX_RETRY(3), .POL_FLIP_EN(1'b1)
  ) u_dut (
    .i_sysclk(clk), .i_rst(rst), .i_enable(enable), .i_qplllock(pll),
    .i_tx_done(txd), .i_rx_done(rxd), .i_rx_byte_align(aln),
    .o_tx_rst(tx_rst), .o_rx_rst(rx_rst), .o_rx_polarity(pol),
    .o_link_up(link_up), .o_fail(fail), .o_state(state), .o_retry_cnt(retry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input string tag, input state_e st, input int max);
    int n = 0;
    while (state != st && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 32'(state), 32'(st));
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_st"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_txr"}, 32'(tx_rst), 32'd1);
    check({tag, "_rxr"}, 32'(rx_rst), 32'd1);
    check({tag, "_pol"}, 32'(pol), 32'd0);
    check({tag, "_lnk"}, 32'(link_up), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_rty"}, 32'(retry), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pll = 1'b0; txd = 1'b0; rxd = 1'b0; aln = 1'b0;
    #1;
    check_rst_vals("rst");
    tick(3);
    rst = 1'b0;
    tick(3);
    check("idle_hold", 32'(state), 32'(ST_IDLE));

    // Nominal bring-up
    enable = 1'b1;
    tick(10);
    pll = 1'b1;
    wait_st("to_txrst", ST_TX_RST, 10);
    check("txrst_tx", 32'(tx_rst), 32'd1);
    tick(3);
    check("txrst_hold", 32'(state), 32'(ST_TX_RST));
    tick(1);
    check("txwait_st", 32'(state), 32'(ST_TX_WAIT));
    check("txwait_tx", 32'(tx_rst), 32'd0);
    check("txwait_rx", 32'(rx_rst), 32'd1);
    tick(10);
    txd = 1'b1;
    wait_st("to_rxrst", ST_RX_RST, 10);
    check("rxrst_rx", 32'(rx_rst), 32'd1);
    wait_st("to_rxwait", ST_RX_WAIT, 10);
    check("rxwait_rx", 32'(rx_rst), 32'd0);
    tick(10);
    rxd = 1'b1;
    wait_st("to_align", ST_ALIGN, 10);
    tick(10);
    aln = 1'b1;
    tick(18);
    check("align_pre", 32'(link_up), 32'd0);
    tick(1);
    check("nom_link", 32'(link_up), 32'd1);
    check("nom_st", 32'(state), 32'(ST_LINK_UP));
    check("nom_rty", 32'(retry), 32'd0);

    // Three unaligned cycles are tolerated
    aln = 1'b0;
    tick(3);
    aln = 1'b1;
    tick(6);
    check("loss3_st", 32'(state), 32'(ST_LINK_UP));
    check("loss3_lnk", 32'(link_up), 32'd1);

    // Four unaligned cycles drop the link without a retry
    aln = 1'b0;
    tick(6);
    check("loss4_st", 32'(state), 32'(ST_RX_RST));
    check("loss4_lnk", 32'(link_up), 32'd0);
    check("loss4_rty", 32'(retry), 32'd0);

    // Alignment glitch at stable count 10 delays link-up by 11 cycles
    wait_st("relink_align", ST_ALIGN, 20);
    aln = 1'b1;
    tick(10);
    aln = 1'b0;
    tick(1);
    aln = 1'b1;
    tick(18);
    check("glitch_pre", 32'(link_up), 32'd0);
    check("glitch_st", 32'(state), 32'(ST_ALIGN));
    tick(1);
    check("glitch_link", 32'(link_up), 32'd1);

    // QPLL lock loss
    pll = 1'b0;
    tick(2);
    check("pll_pre", 32'(state), 32'(ST_LINK_UP));
    tick(1);
    check("pll_st", 32'(state), 32'(ST_WAIT_PLL));
    check("pll_tx", 32'(tx_rst), 32'd1);
    check("pll_rx", 32'(rx_rst), 32'd1);
    check("pll_lnk", 32'(link_up), 32'd0);

    // Polarity retry from an ALIGN timeout
    aln = 1'b0;
    pll = 1'b1;
    wait_st("pol_align", ST_ALIGN, 40);
    tick(63);
    check("pol_pre_st", 32'(state), 32'(ST_ALIGN));
    check("pol_pre_p", 32'(pol), 32'd0);
    tick(1);
    check("pol_st", 32'(state), 32'(ST_RX_RST));
    check("pol_rty", 32'(retry), 32'd1);
    check("pol_p", 32'(pol), 32'd1);
    aln = 1'b1;
    wait_st("pol_link", ST_LINK_UP, 60);
    check("pol_rty0", 32'(retry), 32'd0);
    check("pol_keep", 32'(pol), 32'd1);

    // Exhaustion on TX_WAIT timeouts
    txd = 1'b0;
    enable = 1'b0;
    tick(1);
    check("en0_st", 32'(state), 32'(ST_IDLE));
    check("en0_pol", 32'(pol), 32'd1);
    enable = 1'b1;
    wait_st("ex_txwait", ST_TX_WAIT, 20);
    tick(63);
    check("ex_pre", 32'(state), 32'(ST_TX_WAIT));
    tick(1);
    check("ex1_st", 32'(state), 32'(ST_TX_RST));
    check("ex1_rty", 32'(retry), 32'd1);
    wait_st("ex_fail", ST_FAIL, 200);
    check("ex_fail_o", 32'(fail), 32'd1);
    check("ex_rty", 32'(retry), 32'd3);
    check("ex_tx", 32'(tx_rst), 32'd1);
    check("ex_rx", 32'(rx_rst), 32'd1);
    tick(5);
    check("ex_stay", 32'(state), 32'(ST_FAIL));
    enable = 1'b0;
    tick(1);
    check("ex_idle", 32'(state), 32'(ST_IDLE));
    check("ex_fail0", 32'(fail), 32'd0);
    check("ex_rty0", 32'(retry), 32'd0);

    // Enable drop during RX_WAIT
    txd = 1'b1;
    rxd = 1'b0;
    enable = 1'b1;
    wait_st("dr_rxwait", ST_RX_WAIT, 40);
    enable = 1'b0;
    tick(1);
    check("dr_idle", 32'(state), 32'(ST_IDLE));
    check("dr_tx", 32'(tx_rst), 32'd1);

    // Asynchronous reset during TX_WAIT
    txd = 1'b0;
    enable = 1'b1;
    wait_st("ar_txwait", ST_TX_WAIT, 30);
    #2;
    rst = 1'b1;
    #1;
    check_rst_vals("ar");
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
